// File: rtl/dsc_slice_pixel_feeder.sv
`default_nettype none
// ============================================================================
// dsc_slice_pixel_feeder: raster RGB -> optional YCoCg-R, slice flags, 2-stage
// Revision: 1.0
// ============================================================================
module dsc_slice_pixel_feeder #(
  parameter int BPC = 8,
  parameter int MAX_SLICE_W = 2048,
  parameter int MAX_SLICE_H = 2048,
  localparam int WW = $clog2(MAX_SLICE_W+1),
  localparam int HW = $clog2(MAX_SLICE_H+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  input  logic [WW-1:0] cfg_slice_w,
  input  logic [HW-1:0] cfg_slice_h,
  input  logic          cfg_ycocg,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BPC-1:0] in_r,
  input  logic [BPC-1:0] in_g,
  input  logic [BPC-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BPC:0]  out_c0,
  output logic [BPC:0]  out_c1,
  output logic [BPC:0]  out_c2,
  output logic          out_sol,
  output logic          out_eol,
  output logic          out_sos,
  output logic          out_eos,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [BPC:0] COMP_OFF = {1'b1, {BPC{1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] w_q, w_d, x_q, x_d;
  logic [HW-1:0] h_q, h_d, y_q, y_d;
  logic          ycocg_q, ycocg_d;
  logic          cfg_err_q, cfg_err_d;
  logic          done_q, done_d;

  // Stage 1 holds Co/t in YCoCg mode, or zero-extended R/B in passthrough.
  logic                 s1_valid_q, s1_valid_d;
  logic signed [BPC:0]  s1_a_q, s1_a_d;
  logic signed [BPC:0]  s1_b_q, s1_b_d;
  logic [BPC-1:0]       s1_g_q, s1_g_d;
  logic [3:0]           s1_flags_q, s1_flags_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [BPC:0]         s2_c0_q, s2_c0_d;
  logic [BPC:0]         s2_c1_q, s2_c1_d;
  logic [BPC:0]         s2_c2_q, s2_c2_d;
  logic [3:0]           s2_flags_q, s2_flags_d;

  logic s2_adv, s1_adv, in_fire, out_fire;
  logic x_last, y_last, cfg_bad;
  logic signed [BPC:0] co_in, t_in, cg_s2, y_s2;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_fire  = in_valid && (state_q == ST_RUN) && s1_adv;
    out_fire = s2_valid_q && out_ready;
    x_last   = (x_q == w_q - WW'(1));
    y_last   = (y_q == h_q - HW'(1));
    cfg_bad  = (cfg_slice_w == '0) || (cfg_slice_w > WW'(MAX_SLICE_W)) ||
               (cfg_slice_h == '0) || (cfg_slice_h > HW'(MAX_SLICE_H));
    co_in    = $signed({1'b0, in_r}) - $signed({1'b0, in_b});
    t_in     = $signed({1'b0, in_b}) + (co_in >>> 1);
    cg_s2    = $signed({1'b0, s1_g_q}) - s1_b_q;
    y_s2     = s1_b_q + (cg_s2 >>> 1);
  end

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    x_d        = x_q;
    y_d        = y_q;
    ycocg_d    = ycocg_q;
    cfg_err_d  = 1'b0;
    done_d     = 1'b0;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_g_d     = s1_g_q;
    s1_flags_d = s1_flags_q;
    s2_valid_d = s2_valid_q;
    s2_c0_d    = s2_c0_q;
    s2_c1_d    = s2_c1_q;
    s2_c2_d    = s2_c2_q;
    s2_flags_d = s2_flags_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            w_d     = cfg_slice_w;
            h_d     = cfg_slice_h;
            ycocg_d = cfg_ycocg;
            x_d     = '0;
            y_d     = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (in_fire) begin
          if (x_last) begin
            x_d = '0;
            if (y_last) state_d = ST_DRAIN;
            else        y_d = y_q + HW'(1);
          end else begin
            x_d = x_q + WW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_fire && s2_flags_q[0]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (s1_adv) begin
      s1_valid_d = in_fire;
      if (in_fire) begin
        s1_flags_d = {x_q == '0, x_last, (x_q == '0) && (y_q == '0), x_last && y_last};
        s1_g_d     = in_g;
        if (ycocg_q) begin
          s1_a_d = co_in;
          s1_b_d = t_in;
        end else begin
          s1_a_d = $signed({1'b0, in_r});
          s1_b_d = $signed({1'b0, in_b});
        end
      end
    end

    // Offsets fold the signed chroma into an unsigned BPC+1-bit range.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_flags_d = s1_flags_q;
        if (ycocg_q) begin
          s2_c0_d = $unsigned(y_s2);
          s2_c1_d = $unsigned(s1_a_q) + COMP_OFF;
          s2_c2_d = $unsigned(cg_s2) + COMP_OFF;
        end else begin
          s2_c0_d = $unsigned(s1_a_q);
          s2_c1_d = {1'b0, s1_g_q};
          s2_c2_d = $unsigned(s1_b_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      ycocg_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_g_q     <= '0;
      s1_flags_q <= '0;
      s2_valid_q <= 1'b0;
      s2_c0_q    <= '0;
      s2_c1_q    <= '0;
      s2_c2_q    <= '0;
      s2_flags_q <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      h_q        <= h_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ycocg_q    <= ycocg_d;
      cfg_err_q  <= cfg_err_d;
      done_q     <= done_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_g_q     <= s1_g_d;
      s1_flags_q <= s1_flags_d;
      s2_valid_q <= s2_valid_d;
      s2_c0_q    <= s2_c0_d;
      s2_c1_q    <= s2_c1_d;
      s2_c2_q    <= s2_c2_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  assign in_ready  = (state_q == ST_RUN) && s1_adv;
  assign out_valid = s2_valid_q;
  assign out_c0    = s2_c0_q;
  assign out_c1    = s2_c1_q;
  assign out_c2    = s2_c2_q;
  assign out_sol   = s2_flags_q[3];
  assign out_eol   = s2_flags_q[2];
  assign out_sos   = s2_flags_q[1];
  assign out_eos   = s2_flags_q[0];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dsc_slice_pixel_feeder.sv
`default_nettype none
// ============================================================================
// tb_dsc_slice_pixel_feeder: directed checks of dsc_slice_pixel_feeder
// Revision: 1.0
// ============================================================================
module tb_dsc_slice_pixel_feeder;

  localparam int BPC = 8;
  localparam int MW  = 2048;
  localparam int MH  = 2048;
  localparam int WW  = $clog2(MW+1);
  localparam int HW  = $clog2(MH+1);
  localparam int DW  = 3*(BPC+1);

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_start;
  logic [WW-1:0]  cfg_slice_w;
  logic [HW-1:0]  cfg_slice_h;
  logic           cfg_ycocg;
  logic           in_valid;
  logic           in_ready;
  logic [BPC-1:0] in_r, in_g, in_b;
  logic           out_valid;
  logic           out_ready;
  logic [BPC:0]   out_c0, out_c1, out_c2;
  logic           out_sol, out_eol, out_sos, out_eos;
  logic           busy, done, cfg_err;

  dsc_slice_pixel_feeder #(.BPC(BPC), .MAX_SLICE_W(MW), .MAX_SLICE_H(MH)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_slice_w(cfg_slice_w),
    .cfg_slice_h(cfg_slice_h), .cfg_ycocg(cfg_ycocg), .in_valid(in_valid),
    .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c0(out_c0),
    .out_c1(out_c1), .out_c2(out_c2), .out_sol(out_sol), .out_eol(out_eol),
    .out_sos(out_sos), .out_eos(out_eos), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int pr[64];
  int pg[64];
  int pb[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference transform written directly from the integer YCoCg-R equations.
  function automatic logic [DW-1:0] ref_pix(input int r, input int g, input int b, input bit yc);
    int co, t, cg, y, c1, c2;
    logic [BPC:0] a0, a1, a2;
    if (yc) begin
      co = r - b;
      t  = b + (co >>> 1);
      cg = g - t;
      y  = t + (cg >>> 1);
      c1 = co + (1 << BPC);
      c2 = cg + (1 << BPC);
      a0 = y[BPC:0];
      a1 = c1[BPC:0];
      a2 = c2[BPC:0];
    end else begin
      a0 = r[BPC:0];
      a1 = g[BPC:0];
      a2 = b[BPC:0];
    end
    return {a0, a1, a2};
  endfunction

  function automatic logic [3:0] ref_flags(input int i, input int w, input int h);
    int x, y;
    x = i % w;
    y = i / w;
    return {x == 0, x == w-1, (x == 0) && (y == 0), (x == w-1) && (y == h-1)};
  endfunction

  task automatic start_cfg(input int w, input int h, input bit yc);
    @(negedge clk);
    cfg_slice_w = WW'(w);
    cfg_slice_h = HW'(h);
    cfg_ycocg   = yc;
    cfg_start   = 1'b1;
    @(negedge clk);
    cfg_start   = 1'b0;
  endtask

  task automatic run_slice(input string nm, input int w, input int h, input bit yc,
                           input bit rnd, input bit inj);
    int n, sent, rcv, t_acc0, t_out0, t_last, budget;
    n = w*h; sent = 0; rcv = 0; t_acc0 = -1; t_out0 = -1; t_last = -1; budget = 0;
    start_cfg(w, h, yc);
    chk({nm, "/busy_start"}, 32'(busy), 32'd1);
    while (rcv < n && budget < 3000) begin
      in_valid  = (sent < n) && (!rnd || ($urandom_range(0, 1) == 1));
      if (sent < n) begin
        in_r = BPC'(pr[sent]);
        in_g = BPC'(pg[sent]);
        in_b = BPC'(pb[sent]);
      end
      out_ready = !rnd || ($urandom_range(0, 1) == 1);
      if (inj && sent == 2) begin
        cfg_start   = 1'b1;
        cfg_slice_w = WW'(1);
        cfg_slice_h = HW'(1);
        cfg_ycocg   = !yc;
      end else begin
        cfg_start   = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (rcv < n) begin
          chk({nm, "/data"}, 32'({out_c0, out_c1, out_c2}),
              32'(ref_pix(pr[rcv], pg[rcv], pb[rcv], yc)));
          chk({nm, "/flags"}, 32'({out_sol, out_eol, out_sos, out_eos}),
              32'(ref_flags(rcv, w, h)));
          if (out_ready) begin
            if (t_out0 < 0) t_out0 = cyc;
            t_last = cyc;
            rcv++;
          end
        end else begin
          chk({nm, "/extra_out"}, 32'd1, 32'd0);
        end
      end
      if (in_valid && in_ready) begin
        if (t_acc0 < 0) t_acc0 = cyc;
        sent++;
      end
      budget++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    cfg_start = 1'b0;
    out_ready = 1'b1;
    chk({nm, "/count"}, 32'(rcv), 32'(n));
    chk({nm, "/sent"}, 32'(sent), 32'(n));
    chk({nm, "/done"}, 32'(done), 32'd1);
    chk({nm, "/busy_end"}, 32'(busy), 32'd0);
    chk({nm, "/ovalid_end"}, 32'(out_valid), 32'd0);
    if (!rnd) begin
      chk({nm, "/latency"}, 32'(t_out0 - t_acc0), 32'd2);
      chk({nm, "/throughput"}, 32'(t_last - t_acc0), 32'(n + 1));
    end
    @(negedge clk);
    chk({nm, "/done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic cfg_bad(input string nm, input int w, input int h);
    start_cfg(w, h, 1'b1);
    chk({nm, "/cfg_err"}, 32'(cfg_err), 32'd1);
    chk({nm, "/busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({nm, "/cfg_err_pulse"}, 32'(cfg_err), 32'd0);
    chk({nm, "/busy2"}, 32'(busy), 32'd0);
  endtask

  task automatic ramp();
    for (int i = 0; i < 64; i++) begin
      pr[i] = (i*3) & 255;
      pg[i] = (i*5 + 1) & 255;
      pb[i] = (255 - i*7) & 255;
    end
  endtask

  initial begin
    int sent;
    rst = 1'b1; cfg_start = 1'b0; cfg_slice_w = '0; cfg_slice_h = '0; cfg_ycocg = 1'b0;
    in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset/in_ready", 32'(in_ready), 32'd0);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/done_err", 32'({done, cfg_err}), 32'd0);
    chk("reset/data_flags", 32'({out_c0, out_c1, out_c2, out_sol, out_eol, out_sos, out_eos}), 32'd0);
    rst = 1'b0;

    // Single pixel YCoCg: (255,0,0) -> 63/511/129.
    pr[0] = 255; pg[0] = 0; pb[0] = 0;
    chk("ref/single", 32'(ref_pix(255, 0, 0, 1'b1)), 32'({9'd63, 9'd511, 9'd129}));
    run_slice("single", 1, 1, 1'b1, 1'b0, 1'b0);

    pr[0] = 128; pg[0] = 128; pb[0] = 128;
    pr[1] = 255; pg[1] = 255; pb[1] = 255;
    pr[2] = 0;   pg[2] = 0;   pb[2] = 0;
    run_slice("vec", 3, 1, 1'b1, 1'b0, 1'b0);

    ramp();
    run_slice("pass", 4, 3, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 64; i++) begin
      pr[i] = int'($urandom_range(0, 255));
      pg[i] = int'($urandom_range(0, 255));
      pb[i] = int'($urandom_range(0, 255));
    end
    run_slice("rand_ycc", 7, 5, 1'b1, 1'b1, 1'b0);
    run_slice("rand_pass", 7, 5, 1'b0, 1'b1, 1'b0);

    cfg_bad("w0", 0, 3);
    cfg_bad("wmax1", MW + 1, 3);
    cfg_bad("h0", 3, 0);

    ramp();
    run_slice("inject", 4, 3, 1'b1, 1'b0, 1'b1);

    // Reset after five accepted pixels of a 4x3 slice.
    start_cfg(4, 3, 1'b0);
    sent = 0;
    for (int k = 0; k < 50 && sent < 5; k++) begin
      in_valid = 1'b1;
      in_r = BPC'(pr[sent]); in_g = BPC'(pg[sent]); in_b = BPC'(pb[sent]);
      #1;
      if (in_ready) sent++;
      @(negedge clk);
    end
    chk("rst_mid/sent", 32'(sent), 32'd5);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid/in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid/out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid/busy", 32'(busy), 32'd0);
    chk("rst_mid/data_flags", 32'({out_c0, out_c1, out_c2, out_sol, out_eol, out_sos, out_eos}), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("rst_mid/no_done", 32'({done, cfg_err, out_valid}), 32'd0);
      @(negedge clk);
    end
    run_slice("after_rst", 4, 3, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsc_slice_pixel_feeder.md
# dsc_slice_pixel_feeder

Streaming front-end that takes raster-ordered RGB pixels for one DSC slice and applies the optional RGB→YCoCg-R colour transform. It tags each output pixel with line and slice boundary flags and hands it to the slice encoder over a valid/ready handshake. It is the parametrised RTL successor of the software-side `dsc_cfg_t`/`color_e` handling: bits-per-component, maximum slice geometry and colour mode are configurable, and it adds per-slice sequencing, back-pressure and error reporting. One instance serves one slice at a time. It sits between the pixel input buffer and the DSC prediction/ICH stage.

## Interface
- `BPC`, default 8: bits per input component, legal 8..14.
- `MAX_SLICE_W`, default 2048: maximum slice width in pixels.
- `MAX_SLICE_H`, default 2048: maximum slice height in lines.
- `WW` = `$clog2(MAX_SLICE_W+1)` and `HW` = `$clog2(MAX_SLICE_H+1)`: derived widths, not overridable.

- `clk`, input, 1: the single clock.
- `rst`, input, 1: **synchronous, active-high** reset.
- `cfg_start`, input, 1: one-cycle pulse that latches the config and starts a slice.
- `cfg_slice_w`, input, WW: slice width, legal 1..MAX_SLICE_W.
- `cfg_slice_h`, input, HW: slice height, legal 1..MAX_SLICE_H.
- `cfg_ycocg`, input, 1: 1 = YCoCg-R transform; 0 = RGB passthrough.
- `in_valid`, input, 1: input pixel valid.
- `in_ready`, output, 1: input pixel accepted when both valid and ready are high.
- `in_r`, `in_g`, `in_b`, input, BPC each: pixel components.
- `out_valid`, output, 1: output pixel valid.
- `out_ready`, input, 1: downstream accepts the pixel.
- `out_c0`, `out_c1`, `out_c2`, output, BPC+1 each: Y/Co/Cg, or R/G/B zero-extended.
- `out_sol`, `out_eol`, output, 1 each: first / last pixel of a slice line.
- `out_sos`, `out_eos`, output, 1 each: first / last pixel of the slice.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle pulse when the slice is complete.
- `cfg_err`, output, 1: one-cycle pulse when an illegal config is rejected.

## Operation
- **States:**
  - IDLE: waiting for `cfg_start`.
  - RUN: accepting input pixels.
  - DRAIN: input closed, pipeline emptying.
- **IDLE + `cfg_start`:**
  - If either dimension is 0 or above its maximum: pulse `cfg_err` next cycle and stay in IDLE.
  - Otherwise latch w, h and mode, clear the x/y counters and go to RUN.
- **RUN:**
  - `in_ready` = pipeline stage 1 can advance.
  - Each accepted pixel advances x; at x = w−1, x wraps to 0 and y increments.
  - The pixel accepted at (w−1, h−1) moves the state to DRAIN in the same cycle.
- **DRAIN:**
  - `in_ready` = 0.
  - When the eos pixel handshakes at the output, go to IDLE; `done` pulses on the following cycle.
- **Flags**, computed from the counters at input acceptance and carried through the pipeline:
  - sol = (x==0); eol = (x==w−1).
  - sos = (x==0 && y==0); eos = (x==w−1 && y==h−1).
  - When w = 1, sol and eol are both set on every pixel. When w = h = 1, all four flags are set on the single pixel.
- **YCoCg-R transform** (signed, BPC+1 bits internally; `>>>` is arithmetic shift):
  - Co = R−B
  - t = B + (Co>>>1)
  - Cg = G−t
  - Y = t + (Cg>>>1)
  - Outputs: c0 = Y (MSB is 0), c1 = Co + 2^BPC, c2 = Cg + 2^BPC. The results are unsigned and always in range; no saturation.
- **Passthrough:** c0, c1, c2 = {0,R}, {0,G}, {0,B}.
- **Ignored events:**
  - `cfg_start` in RUN or DRAIN is ignored, with no error and no re-latch.
  - `in_valid` in IDLE or DRAIN is ignored; `in_ready` is 0 there.

## Timing
- **Pipeline:** two register stages.
  - Stage 1 registers Co, t, G and the flags.
  - Stage 2 registers Y, Co+off, Cg+off, or the passthrough values.
- **Latency:** input handshake at cycle N gives `out_valid` at cycle N+2 when not stalled.
- **Throughput:** 1 pixel/clk with `out_ready` held high.
- **Stall:** the whole pipeline stalls. A stage advances when it is empty or the stage after it advances.
  - `in_ready` is combinational from `out_ready` through the stage valids. There is no bubble insertion.
  - While `out_valid && !out_ready`, all outputs are held stable.
- **Reset values:**
  - `in_ready`, `out_valid`, `busy`, `done`, `cfg_err` and all flags = 0.
  - `out_c*` = 0; state = IDLE; counters = 0.
- **Reset mid-slice:** next cycle is IDLE with the pipeline flushed. No `done` or `cfg_err` pulse.
- **Same-cycle events:**
  - `done` and a new `cfg_start` may coincide. The start is honoured because the state is already IDLE.
  - `cfg_start` together with `rst`: reset wins.

## Test plan
- **YCoCg, BPC=8, w=h=1, single pixel:**
  - RGB (255,0,0) → c0=63, c1=511, c2=129.
  - sol, eol, sos and eos all = 1; `done` 1 cycle after the output handshake; latency exactly 2 cycles.
- **YCoCg vectors:**
  - (128,128,128) → (128,256,256).
  - (255,255,255) → (255,256,256).
  - (0,0,0) → (0,256,256).
- **Passthrough, w=4, h=3, ramp data, `out_ready` always 1:**
  - 12 outputs, data equal to input.
  - sol at indices 0/4/8, eol at 3/7/11, sos only at 0, eos only at 11.
  - Full throughput.
- **Random back-pressure (`out_ready` 50%) and random `in_valid` gaps, w=7, h=5:**
  - Output matches the reference model in order, with no loss or duplication.
  - Outputs are stable during stalls.
- **Config errors:**
  - `cfg_start` with w=0 → `cfg_err` pulse; `busy` stays 0.
  - w=MAX_SLICE_W+1 → `cfg_err` pulse.
  - `cfg_start` during RUN → ignored; the original slice completes normally.
- **Reset in RUN after 5 of 12 pixels:**
  - All outputs return to reset values next cycle, with no `done`.
  - A new slice started afterwards produces correct flags from sos.
